bip_result_tx: RTL and testbench
================================

Name: bip_result_tx

Overview:
- Downstream stage of the BIP core inside Top: when the core halts, captures PC, accumulator and cycle counter and serializes them as six bytes on the board UART TX line (UART_RXD_OUT at Top level).
- Contains its own bit-period counter, byte sequencer and shift register, so no external UART is needed.
- Lets the bench or host read the program result without probing internal nets.

Parameters:
- DATA_WIDTH, 16, width of accumulator and cycle-count inputs.
- PC_WIDTH, 11, width of the PC input; zero-extended to DATA_WIDTH for transmission.
- UART_DATA_SIZE, 8, data bits per UART frame; fixed at 8 for this block.
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous active-high reset.
- i_halt  input  1  halt level from the BIP control unit; a rising edge triggers a report.
- i_pc  input  PC_WIDTH  program counter at halt.
- i_acc  input  DATA_WIDTH  accumulator at halt.
- i_cycles  input  DATA_WIDTH  executed-cycle count at halt.
- o_tx  output  1  UART serial out; idle high.
- o_busy  output  1  high while a report is being transmitted.
- o_done  output  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (async, i_rst=1): o_tx=1, o_busy=0, o_done=0, state=IDLE, all counters 0, halt_q=0.
- All outputs are registered.
- Edge detect: halt_q <= i_halt every cycle; trigger = i_halt & ~halt_q.
- IDLE: on a clock edge where trigger=1:
  - Latch frame = {zext(i_pc), i_acc, i_cycles} (48 bits).
  - Byte index = 0, bit counter = 0.
  - Set o_busy=1, drive o_tx=0, go to START.
- Byte order: PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CYC[15:8], CYC[7:0].
- Bit order within each byte: LSB first.
- START: hold o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit 0.
- DATA: each bit is held for CLKS_PER_BIT cycles. After bit 7, go to STOP with o_tx=1.
- STOP: hold o_tx=1 for CLKS_PER_BIT cycles, then:
  - If byte index < 5: increment the index and go to START (o_tx=0). No idle gap between bytes.
  - If byte index = 5: go to IDLE with o_busy=0 and o_done=1 for exactly that one cycle.
- Frame length: 10*CLKS_PER_BIT cycles per byte. A full report is 60*CLKS_PER_BIT cycles from the trigger edge to the o_busy fall (960 cycles at default).
- Trigger while o_busy=1: ignored. No queueing; the latched frame is not updated.
- i_halt held high: one report only. A new report requires i_halt low then high. A rising edge on the same cycle that o_busy falls is ignored.
- Input changes after the trigger edge: do not affect the report.
- Reset mid-report: o_tx returns to 1 immediately (asynchronously) and the report is abandoned. No o_done pulse.
- Bit-period counter: width clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1.

Test Plan:
- Reset idle: assert i_rst for 5 cycles, then release with i_halt=0 -> o_tx=1, o_busy=0, o_done=0 for 200 cycles.
- Basic report: i_pc=0x005, i_acc=0x1234, i_cycles=0x00A0, raise i_halt -> decoded bytes 0x00,0x05,0x12,0x34,0x00,0xA0. Each start bit is 16 cycles low. o_done pulses at cycle 960 after the trigger edge.
- Input change during report: change i_acc to 0xFFFF at cycle 100 after the trigger -> bytes 3-4 still 0x12,0x34.
- Re-trigger while busy: toggle i_halt low then high at cycle 300 -> still exactly 6 bytes, one o_done pulse. A second toggle after o_done -> second complete report.
- Level hold: keep i_halt=1 for 3000 cycles -> exactly one report.
- Reset mid-report: assert i_rst at cycle 250 (inside byte 2) -> o_tx=1 and o_busy=0 at once, no o_done. Lower i_halt, release reset, raise i_halt -> a complete, correct report.

Source files
------------

// File: rtl/bip_result_tx.sv
// rtl/bip_result_tx.sv - serializes the halted BIP core's PC, accumulator and cycle count as six UART bytes
module bip_result_tx #(
    parameter int DATA_WIDTH     = 16,
    parameter int PC_WIDTH       = 11,
    parameter int UART_DATA_SIZE = 8,
    parameter int CLKS_PER_BIT   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_halt,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_cycles,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int FRAME_W   = 3 * DATA_WIDTH;
    localparam int NUM_BYTES = FRAME_W / UART_DATA_SIZE;
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W     = $clog2(UART_DATA_SIZE);
    localparam int BYTE_W    = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                    state_q;
    logic                      halt_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [BIT_W-1:0]          bit_q;
    logic [BYTE_W-1:0]         byte_q;
    logic [FRAME_W-1:0]        frame_q;
    logic [UART_DATA_SIZE-1:0] shift_q;

    logic [DATA_WIDTH-1:0] pc_ext;
    logic [FRAME_W-1:0]    frame_d;
    logic                  trigger;
    logic                  bit_end;

    assign pc_ext  = DATA_WIDTH'(i_pc);
    assign frame_d = {pc_ext, i_acc, i_cycles};
    assign trigger = i_halt & ~halt_q;
    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            shift_q <= '0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            halt_q <= i_halt;
            o_done <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        frame_q <= frame_d;
                        byte_q  <= '0;
                        bit_q   <= '0;
                        cnt_q   <= '0;
                        o_busy  <= 1'b1;
                        o_tx    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    // The outgoing byte always sits at the top of frame_q; LSB goes first.
                    if (bit_end) begin
                        shift_q <= frame_q[FRAME_W-1 -: UART_DATA_SIZE] >> 1;
                        o_tx    <= frame_q[FRAME_W-UART_DATA_SIZE];
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_q == BIT_W'(UART_DATA_SIZE - 1)) begin
                            o_tx    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            o_tx    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (byte_q == BYTE_W'(NUM_BYTES - 1)) begin
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            byte_q  <= byte_q + 1'b1;
                            frame_q <= frame_q << UART_DATA_SIZE;
                            o_tx    <= 1'b0;
                            state_q <= S_START;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_result_tx.sv
// tb/tb_bip_result_tx.sv - directed self-checking bench for bip_result_tx
module tb_bip_result_tx;

    localparam int N      = 16;
    localparam int REPORT = 60 * N;
    localparam int MAXS   = 3000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_halt = 1'b0;
    logic [10:0] i_pc = '0;
    logic [15:0] i_acc = '0;
    logic [15:0] i_cycles = '0;
    logic        o_tx, o_busy, o_done;

    int total = 0;
    int bad = 0;

    logic tx_s   [MAXS];
    logic busy_s [MAXS];
    logic done_s [MAXS];

    // action hooks applied during capture: 0 none, 1 acc change, 2 halt toggle, 3 reset
    int act_kind = 0;

    always #5 i_clk = ~i_clk;

    bip_result_tx #(
        .DATA_WIDTH(16), .PC_WIDTH(11), .UART_DATA_SIZE(8), .CLKS_PER_BIT(N)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_halt(i_halt), .i_pc(i_pc),
        .i_acc(i_acc), .i_cycles(i_cycles), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx(input logic [47:0] frame, input int k);
        int b, p;
        logic [7:0] byt;
        if (k >= REPORT) return 1'b1;
        b   = k / (10 * N);
        p   = (k % (10 * N)) / N;
        byt = frame[47 - 8*b -: 8];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return byt[p-1];
    endfunction

    // Raises i_halt after a low cycle; returns just after the trigger edge.
    task automatic trigger_report();
        i_halt = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_halt = 1'b1;
        @(posedge i_clk);
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            tx_s[k]   = o_tx;
            busy_s[k] = o_busy;
            done_s[k] = o_done;
            if (act_kind == 1 && k == 100) i_acc = 16'hFFFF;
            if (act_kind == 2 && k == 300) i_halt = 1'b0;
            if (act_kind == 2 && k == 302) i_halt = 1'b1;
        end
    endtask

    task automatic check_report(input string tag, input logic [47:0] frame, input int n);
        int wave_err = 0;
        int dones = 0;
        int busys = 0;
        logic [7:0] byt;
        for (int k = 0; k < n; k++) begin
            if (tx_s[k] !== exp_tx(frame, k)) wave_err++;
            if (done_s[k] === 1'b1) dones++;
            if (busy_s[k] === 1'b1) busys++;
        end
        chk({tag, "_wave_err"}, 64'(wave_err), 64'd0);
        chk({tag, "_done_cnt"}, 64'(dones), 64'd1);
        chk({tag, "_done_at"}, 64'(done_s[REPORT]), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(busys), 64'(REPORT));
        chk({tag, "_busy_last"}, {62'd0, busy_s[REPORT-1], busy_s[REPORT]}, 64'b10);
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < 8; j++) byt[j] = tx_s[b*10*N + (1+j)*N + N/2];
            chk($sformatf("%s_byte%0d", tag, b), 64'(byt), 64'(frame[47 - 8*b -: 8]));
        end
    endtask

    initial begin
        int idle_err;
        int rst_done;

        // reset idle
        repeat (5) @(posedge i_clk);
        #1 i_rst = 1'b0;
        idle_err = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) idle_err++;
        end
        chk("reset_idle", 64'(idle_err), 64'd0);

        // basic report
        i_pc = 11'h005; i_acc = 16'h1234; i_cycles = 16'h00A0;
        act_kind = 0;
        trigger_report();
        capture(1000);
        check_report("basic", 48'h0005_1234_00A0, 1000);

        // inputs change mid-report
        act_kind = 1;
        trigger_report();
        capture(1000);
        check_report("acc_chg", 48'h0005_1234_00A0, 1000);

        // re-trigger while busy, then a genuine second report
        i_acc = 16'h1234;
        act_kind = 2;
        trigger_report();
        capture(1000);
        check_report("retrig", 48'h0005_1234_00A0, 1000);
        act_kind = 0;
        i_pc = 11'h7FF; i_acc = 16'hA5C3; i_cycles = 16'h0102;
        trigger_report();
        capture(1000);
        check_report("second", 48'h07FF_A5C3_0102, 1000);

        // level hold: one report only
        i_pc = 11'h123; i_acc = 16'h8001; i_cycles = 16'hFFFE;
        trigger_report();
        capture(3000);
        check_report("hold", 48'h0123_8001_FFFE, 3000);

        // reset mid-report
        i_pc = 11'h005; i_acc = 16'h1234; i_cycles = 16'h00A0;
        trigger_report();
        capture(250);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_tx", 64'(o_tx), 64'd1);
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        rst_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0) rst_done++;
        end
        i_halt = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) rst_done++;
        end
        chk("rst_no_done", 64'(rst_done), 64'd0);
        i_pc = 11'h3C0; i_acc = 16'h0F0F; i_cycles = 16'h0042;
        trigger_report();
        capture(1000);
        check_report("after_rst", 48'h03C0_0F0F_0042, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
